// File: rtl/key_debounce.sv
// Per-key synchronizer and stability-counter debouncer for active-low push-buttons.
// Optional release strobe port is compiled in when KEY_DEBOUNCE_RELEASE_EN is defined.
module key_debounce #(
    parameter int unsigned KEYS            = 4,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic            clk50m_i,
    input  logic            rst_n_i,
    input  logic [KEYS-1:0] key_i,
    output logic [KEYS-1:0] key_o,
    output logic [KEYS-1:0] key_press_o
`ifdef KEY_DEBOUNCE_RELEASE_EN
    ,
    output logic [KEYS-1:0] key_release_o
`endif
);

    localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    for (genvar k = 0; k < KEYS; k++) begin : g_key
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   stable_q;
        logic [CNT_W-1:0]       cnt_q;
        logic                   key_q;
        logic                   press_q;
        logic                   synced_c;
        logic                   accept_c;

        assign synced_c = sync_q[SYNC_STAGES-1];
        assign accept_c = (synced_c != stable_q) && (cnt_q == CNT_LAST);

        // Metastability chain; resets to the released (high) level.
        always_ff @(posedge clk50m_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                sync_q <= '1;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], key_i[k]};
            end
        end

        // Stability counter: any match clears it, a full run of mismatches commits.
        always_ff @(posedge clk50m_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                stable_q <= 1'b1;
                cnt_q    <= '0;
                key_q    <= 1'b0;
                press_q  <= 1'b0;
            end else begin
                press_q <= 1'b0;
                if (synced_c == stable_q) begin
                    cnt_q <= '0;
                end else if (accept_c) begin
                    stable_q <= synced_c;
                    cnt_q    <= '0;
                    key_q    <= ~synced_c;
                    press_q  <= ~synced_c;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end

        assign key_o[k]       = key_q;
        assign key_press_o[k] = press_q;

`ifdef KEY_DEBOUNCE_RELEASE_EN
        logic release_q;

        always_ff @(posedge clk50m_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                release_q <= 1'b0;
            end else begin
                release_q <= accept_c & synced_c;
            end
        end

        assign key_release_o[k] = release_q;
`endif
    end

endmodule
